// File: rtl/gates_arbiter.sv
// gates_arbiter
//   Round-robin arbiter and sequencer that shares one external combinational
//   gates unit among NUM_REQ requesters. One operation is in flight at a time:
//   IDLE (arbitrate and capture operands) -> EXEC (unit settles, result is
//   selected) -> RESP (result held until accepted) -> IDLE.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b        operand bit i belongs to requester i
//   req_op              3-bit opcode per requester, bits [3i+2:3i]
//   gu_a, gu_b          registered operands driven to the shared gates unit
//   gu_and..gu_xnor     results returned by the shared gates unit
//   resp_valid/ready    response handshake
//   resp_data, resp_err selected result / illegal-opcode flag
//   resp_id             index of the requester that issued the operation
//   busy                high whenever the FSM is not in IDLE
//   done_count          completed responses, saturating
//   dbg_state           current FSM state (0 IDLE, 1 EXEC, 2 RESP)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid may be raised or dropped freely by requesters (a dropped
// request just loses arbitration); the response side holds valid and its
// payload stable from assertion until the transfer edge.
module gates_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   req_a,
  input  logic [NUM_REQ-1:0]   req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic                 gu_a,
  output logic                 gu_b,
  input  logic                 gu_and,
  input  logic                 gu_or,
  input  logic                 gu_not,
  input  logic                 gu_xor,
  input  logic                 gu_nand,
  input  logic                 gu_nor,
  input  logic                 gu_xnor,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_data,
  output logic                 resp_err,
  output logic [ID_W-1:0]      resp_id,
  output logic                 busy,
  output logic [CNT_W-1:0]     done_count,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              gu_a_q, gu_a_d;
  logic              gu_b_q, gu_b_d;
  logic [2:0]        op_q, op_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic [CNT_W-1:0]  done_count_q, done_count_d;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  logic found;
  int   grant_int;
  int   scan;

  always_comb begin
    found     = 1'b0;
    grant_int = 0;
    scan      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[scan]) begin
        found     = 1'b1;
        grant_int = scan;
      end
    end
  end

  // Ready is only offered in IDLE and is suppressed while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (found && (state_q == S_IDLE) && !rst) begin
      req_ready[grant_int] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gu_a_d       = gu_a_q;
    gu_b_d       = gu_b_q;
    op_d         = op_q;
    resp_id_d    = resp_id_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    done_count_d = done_count_q;
    case (state_q)
      S_IDLE: begin
        if (|req_ready) begin
          gu_a_d    = req_a[grant_int];
          gu_b_d    = req_b[grant_int];
          op_d      = req_op[3*grant_int +: 3];
          resp_id_d = ID_W'(grant_int);
          rr_ptr_d  = ID_W'((grant_int + 1) % NUM_REQ);
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        // gu_* have settled on the operands registered at the accept edge.
        resp_err_d = 1'b0;
        case (op_q)
          3'd0:    resp_data_d = gu_and;
          3'd1:    resp_data_d = gu_or;
          3'd2:    resp_data_d = gu_not;
          3'd3:    resp_data_d = gu_xor;
          3'd4:    resp_data_d = gu_nand;
          3'd5:    resp_data_d = gu_nor;
          3'd6:    resp_data_d = gu_xnor;
          default: begin
            resp_data_d = 1'b0;
            resp_err_d  = 1'b1;
          end
        endcase
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          if (done_count_q != {CNT_W{1'b1}}) begin
            done_count_d = done_count_q + CNT_W'(1);
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      gu_a_q       <= 1'b0;
      gu_b_q       <= 1'b0;
      op_q         <= '0;
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gu_a_q       <= gu_a_d;
      gu_b_q       <= gu_b_d;
      op_q         <= op_d;
      resp_id_q    <= resp_id_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      done_count_q <= done_count_d;
    end
  end

  assign gu_a       = gu_a_q;
  assign gu_b       = gu_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != S_IDLE);
  assign done_count = done_count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_gates_arbiter.sv
module tb_gates_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   req_a = '0;
  logic [NUM_REQ-1:0]   req_b = '0;
  logic [3*NUM_REQ-1:0] req_op = '0;
  logic                 gu_a, gu_b;
  logic                 gu_and, gu_or, gu_not, gu_xor, gu_nand, gu_nor, gu_xnor;
  logic                 resp_valid;
  logic                 resp_ready = 1'b0;
  logic                 resp_data, resp_err;
  logic [ID_W-1:0]      resp_id;
  logic                 busy;
  logic [CNT_W-1:0]     done_count;
  logic [1:0]           dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Shared combinational gates unit.
  assign gu_and  = gu_a & gu_b;
  assign gu_or   = gu_a | gu_b;
  assign gu_not  = ~gu_a;
  assign gu_xor  = gu_a ^ gu_b;
  assign gu_nand = ~(gu_a & gu_b);
  assign gu_nor  = ~(gu_a | gu_b);
  assign gu_xnor = ~(gu_a ^ gu_b);

  gates_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .gu_a(gu_a), .gu_b(gu_b),
    .gu_and(gu_and), .gu_or(gu_or), .gu_not(gu_not), .gu_xor(gu_xor),
    .gu_nand(gu_nand), .gu_nor(gu_nor), .gu_xnor(gu_xnor),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .resp_id(resp_id),
    .busy(busy), .done_count(done_count), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_req(input int idx, input logic a, input logic b, input logic [2:0] op);
    req_valid[idx]       = 1'b1;
    req_a[idx]           = a;
    req_b[idx]           = b;
    req_op[3*idx +: 3]   = op;
  endtask

  // Complete one operation from IDLE with immediate response acceptance.
  task automatic run_op(input int idx, input logic a, input logic b, input logic [2:0] op);
    set_req(idx, a, b, op);
    resp_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    step();
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    step();
    n_checks++;
    if ({gu_a, gu_b, resp_valid, resp_data, resp_err, resp_id, busy, done_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gu_a=%b gu_b=%b rv=%b rd=%b re=%b id=%0d busy=%b cnt=%0d want all 0",
               gu_a, gu_b, resp_valid, resp_data, resp_err, resp_id, busy, done_count);
    end
    req_valid = '0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 1'b0, 3'd3);
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    step();
    req_valid = '0;
    n_checks++;
    if (busy !== 1'b1 || gu_a !== 1'b1 || gu_b !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_exec: busy=%b gu_a=%b gu_b=%b rv=%b want 1 1 0 0", busy, gu_a, gu_b, resp_valid);
    end
    step();
    n_checks++;
    if (resp_valid !== 1'b1 || resp_data !== 1'b1 || resp_id !== 2'd0 || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL single_resp: rv=%b rd=%b id=%0d err=%b want 1 1 0 0", resp_valid, resp_data, resp_id, resp_err);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || done_count !== 4'd1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_done: rv=%b cnt=%0d busy=%b want 0 1 0", resp_valid, done_count, busy);
    end
  endtask

  task automatic test_round_robin();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    logic [NUM_REQ-1:0] exp_oh;
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b1, 3'd0);
    resp_ready = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      exp_oh = '0;
      exp_oh[exp_g[n]] = 1'b1;
      n_checks++;
      if (req_ready !== exp_oh) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", n, req_ready, exp_oh);
      end
      step();
      n_checks++;
      if (req_ready !== 4'b0000 || busy !== 1'b1) begin
        n_fail++; $display("FAIL rr_hold[%0d]: ready=%b busy=%b want 0000 1", n, req_ready, busy);
      end
      step();
      n_checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(exp_g[n]) || resp_data !== 1'b1) begin
        n_fail++; $display("FAIL rr_resp[%0d]: rv=%b id=%0d rd=%b want 1 %0d 1", n, resp_valid, resp_id, resp_data, exp_g[n]);
      end
      step();
    end
    req_valid = '0;
    resp_ready = 1'b0;
  endtask

  task automatic test_truth_table();
    // Truth tables indexed by {a,b}.
    logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0011, 4'b0110,
                           4'b0111, 4'b0001, 4'b1001, 4'b0000};
    logic [1:0] ab;
    logic exp_d, exp_e;
    resp_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      for (int k = 0; k < 4; k++) begin
        ab = 2'(k);
        set_req(2, ab[1], ab[0], 3'(op));
        step();
        req_valid = '0;
        step();
        exp_d = tt[op][k];
        exp_e = (op == 7);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_data !== exp_d || resp_err !== exp_e || resp_id !== 2'd2) begin
          n_fail++;
          $display("FAIL tt op=%0d a=%b b=%b: rv=%b rd=%b err=%b id=%0d want 1 %b %b 2",
                   op, ab[1], ab[0], resp_valid, resp_data, resp_err, resp_id, exp_d, exp_e);
        end
        step();
      end
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int held_bad = 0;
    set_req(1, 1'b1, 1'b1, 3'd0);
    step();
    req_valid = '0;
    step();
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (resp_valid !== 1'b1 || resp_data !== 1'b1 || resp_id !== 2'd1 || resp_err !== 1'b0 ||
          req_ready !== 4'b0000 || busy !== 1'b1) begin
        held_bad++;
        $display("FAIL bp_hold cycle %0d: rv=%b rd=%b id=%0d err=%b ready=%b busy=%b",
                 c, resp_valid, resp_data, resp_id, resp_err, req_ready, busy);
      end
      step();
    end
    n_checks++;
    if (held_bad != 0) n_fail++;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    // rr_ptr is now 2, so requester 3 wins over requester 0.
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL bp_release: rv=%b ready=%b want 0 1000", resp_valid, req_ready);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_reset_mid_exec();
    int stray = 0;
    set_req(3, 1'b1, 1'b1, 3'd1);
    resp_ready = 1'b1;
    step();
    req_valid = '0;
    req_valid[1] = 1'b1;
    req_valid[2] = 1'b1;
    n_checks++;
    if (dbg_state !== 2'd1) begin
      n_fail++; $display("FAIL rst_pre_state: got %0d want 1", dbg_state);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({gu_a, gu_b, resp_valid, resp_data, resp_id, busy, done_count} !== '0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid: gu_a=%b gu_b=%b rv=%b rd=%b id=%0d busy=%b cnt=%0d ready=%b want all 0",
               gu_a, gu_b, resp_valid, resp_data, resp_id, busy, done_count, req_ready);
    end
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL rst_next_grant: got %b want 0010", req_ready);
    end
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (resp_valid !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++; $display("FAIL rst_no_resp: resp_valid seen %0d cycles want 0", stray);
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 14; i++) run_op(i % NUM_REQ, 1'b0, 1'b1, 3'(i % 8));
    n_checks++;
    if (done_count !== 4'd14) begin
      n_fail++; $display("FAIL sat_pre: got %0d want 14", done_count);
    end
    run_op(0, 1'b1, 1'b1, 3'd7);
    n_checks++;
    if (done_count !== 4'd15) begin
      n_fail++; $display("FAIL sat_max: got %0d want 15", done_count);
    end
    run_op(1, 1'b1, 1'b0, 3'd2);
    n_checks++;
    if (done_count !== 4'd15) begin
      n_fail++; $display("FAIL sat_hold: got %0d want 15", done_count);
    end
    resp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_truth_table();
    test_backpressure();
    test_reset_mid_exec();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
